// File: rtl/otsu_histogram_if.sv
// Pixel-in / histogram-pair-out bundle for the Otsu histogram stage.
// The histogram block is the slave; the upstream/downstream side is the master.
interface otsu_histogram_if #(
  parameter int unsigned PIXEL_W = 8,
  parameter int unsigned COUNT_W = 32
) ();
  logic               start;
  logic               pix_valid;
  logic [PIXEL_W-1:0] pix_data;
  logic               frame_end;
  logic               out_ready;
  logic               out_valid;
  logic [PIXEL_W-1:0] out_i;
  logic [COUNT_W-1:0] out_n_i;
  logic [COUNT_W-1:0] total;
  logic               busy;
  logic               done;

  modport master (
    output start, pix_valid, pix_data, frame_end, out_ready,
    input  out_valid, out_i, out_n_i, total, busy, done
  );

  modport slave (
    input  start, pix_valid, pix_data, frame_end, out_ready,
    output out_valid, out_i, out_n_i, total, busy, done
  );
endinterface

// File: rtl/otsu_histogram.sv
// 256-bin (2**PIXEL_W) intensity histogram: clear, accumulate a pixel stream through a
// read-modify-write pipeline, then drain (i, n_i) pairs in ascending order with valid/ready.
module otsu_histogram #(
  parameter int unsigned PIXEL_W = 8,
  parameter int unsigned COUNT_W = 32
) (
  input logic             clk,
  input logic             reset,
  otsu_histogram_if.slave bus
);
  localparam int unsigned NumBins = 2 ** PIXEL_W;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StClear = 3'd1;
  localparam logic [2:0] StAccum = 3'd2;
  localparam logic [2:0] StFlush = 3'd3;
  localparam logic [2:0] StDrain = 3'd4;
  localparam logic [2:0] StDone  = 3'd5;

  localparam logic [PIXEL_W-1:0] LastBin  = '1;
  localparam logic [COUNT_W-1:0] CountMax = '1;

  logic [COUNT_W-1:0] mem [NumBins];

  logic [2:0]         state_q, state_d;
  logic [PIXEL_W-1:0] idx_q, idx_d;
  logic [COUNT_W-1:0] total_q, total_d;
  logic               out_valid_q, out_valid_d;
  logic [PIXEL_W-1:0] out_i_q, out_i_d;

  logic               s1_valid_q;
  logic [PIXEL_W-1:0] s1_addr_q;
  logic               w_valid_q;
  logic [PIXEL_W-1:0] w_addr_q;
  logic [COUNT_W-1:0] w_data_q;
  logic [COUNT_W-1:0] rd_q;

  logic               accept;
  logic               drain_load;
  logic               rd_en;
  logic [PIXEL_W-1:0] rd_addr;
  logic [COUNT_W-1:0] base;
  logic [COUNT_W-1:0] inc;

  assign accept  = (state_q == StAccum) && bus.pix_valid;
  assign rd_en   = accept || drain_load;
  assign rd_addr = drain_load ? idx_q : bus.pix_data;

  // The previous pixel's write lands on the same edge as this pixel's read, so take its
  // result from the write-stage register when the addresses match.
  assign base = (w_valid_q && (w_addr_q == s1_addr_q)) ? w_data_q : rd_q;
  assign inc  = (base == CountMax) ? base : base + COUNT_W'(1);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    total_d     = total_q;
    out_valid_d = out_valid_q;
    out_i_d     = out_i_q;
    drain_load  = 1'b0;
    case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          state_d = StClear;
          idx_d   = '0;
        end
      end
      StClear: begin
        total_d = '0;
        idx_d   = idx_q + PIXEL_W'(1);
        if (idx_q == LastBin) state_d = StAccum;
      end
      StAccum: begin
        if (bus.pix_valid && (total_q != CountMax)) total_d = total_q + COUNT_W'(1);
        if (bus.frame_end) begin
          state_d = StFlush;
          idx_d   = '0;
        end
      end
      StFlush: begin
        // idx doubles as the 2-cycle flush counter and leaves DRAIN starting at bin 0.
        idx_d = idx_q + PIXEL_W'(1);
        if (idx_q != '0) begin
          state_d = StDrain;
          idx_d   = '0;
        end
      end
      StDrain: begin
        if (out_valid_q && bus.out_ready && (out_i_q == LastBin)) begin
          state_d     = StDone;
          out_valid_d = 1'b0;
        end else if (!out_valid_q || bus.out_ready) begin
          drain_load  = 1'b1;
          out_valid_d = 1'b1;
          out_i_d     = idx_q;
          idx_d       = idx_q + PIXEL_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (state_q == StClear) begin
      mem[idx_q] <= '0;
    end else if (s1_valid_q) begin
      mem[s1_addr_q] <= inc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      total_q     <= '0;
      out_valid_q <= 1'b0;
      out_i_q     <= '0;
      s1_valid_q  <= 1'b0;
      s1_addr_q   <= '0;
      w_valid_q   <= 1'b0;
      w_addr_q    <= '0;
      w_data_q    <= '0;
      rd_q        <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      total_q     <= total_d;
      out_valid_q <= out_valid_d;
      out_i_q     <= out_i_d;
      s1_valid_q  <= accept;
      s1_addr_q   <= bus.pix_data;
      w_valid_q   <= s1_valid_q;
      w_addr_q    <= s1_addr_q;
      w_data_q    <= inc;
      if (rd_en) rd_q <= mem[rd_addr];
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_i     = out_i_q;
  assign bus.out_n_i   = out_valid_q ? rd_q : '0;
  assign bus.total     = total_q;
  assign bus.busy      = (state_q == StClear) || (state_q == StAccum) ||
                         (state_q == StFlush) || (state_q == StDrain);
  assign bus.done      = (state_q == StDone) && !bus.start;
endmodule

// File: tb/tb_otsu_histogram.sv
// Directed bench for otsu_histogram: table of frames with expected bin counts and totals,
// plus hand-written sequences for stray start and reset during drain.
module tb_otsu_histogram;
  localparam int unsigned PW = 8;
  localparam int unsigned CW = 10;  // narrow counters so saturation is reachable
  localparam int NB = 256;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  otsu_histogram_if #(.PIXEL_W(PW), .COUNT_W(CW)) bus ();
  otsu_histogram #(.PIXEL_W(PW), .COUNT_W(CW)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    string name;
    int a;
    int b;
    int na;
    int nb;
    int mode;      // 0 runs, 1 alternate a/b, 2 runs with idle gaps, 3 empty
    int rdy_mode;  // 0 always ready, 1 random ready
    int exp_a;
    int exp_b;
    int exp_total;
  } frame_t;

  frame_t vecs[7];
  int checks = 0;
  int errors = 0;
  int got_n[NB];
  int n_got;
  int pq[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input int junk);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("busy_after_start", int'(bus.busy), 1);
    check("done_after_start", int'(bus.done), 0);
    for (int k = 0; k < NB; k++) begin
      bus.pix_valid = 1'b1;
      bus.pix_data  = PW'(junk);
      bus.frame_end = (k % 64 == 3);
      tick();
    end
    bus.pix_valid = 1'b0;
    bus.frame_end = 1'b0;
    check("total_after_clear", int'(bus.total), 0);
  endtask

  task automatic drain(input int rmode, input int stop_at, input int budget);
    int  held_i;
    int  held_n;
    bit  holding;
    int  cyc;
    n_got   = 0;
    holding = 1'b0;
    held_i  = 0;
    held_n  = 0;
    cyc     = 0;
    while (n_got < NB && cyc < budget) begin
      if (holding) begin
        check("valid_held", int'(bus.out_valid), 1);
        check("i_held", int'(bus.out_i), held_i);
        check("n_held", int'(bus.out_n_i), held_n);
      end
      if (bus.out_valid && stop_at == int'(bus.out_i)) break;
      bus.out_ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      holding = 1'b0;
      if (bus.out_valid) begin
        if (bus.out_ready) begin
          check("seq", int'(bus.out_i), n_got);
          got_n[n_got] = int'(bus.out_n_i);
          n_got++;
        end else begin
          holding = 1'b1;
          held_i  = int'(bus.out_i);
          held_n  = int'(bus.out_n_i);
        end
      end
      tick();
      cyc++;
    end
    if (cyc >= budget) check("drain_timeout", cyc, -1);
    bus.out_ready = 1'b0;
  endtask

  task automatic send_pixels();
    if (pq.size() == 0) begin
      bus.frame_end = 1'b1;
      tick();
    end else begin
      for (int k = 0; k < pq.size(); k++) begin
        bus.pix_valid = (pq[k] >= 0);
        bus.pix_data  = PW'((pq[k] >= 0) ? pq[k] : 0);
        bus.frame_end = (k == pq.size() - 1);
        tick();
      end
    end
    bus.pix_valid = 1'b0;
    bus.frame_end = 1'b0;
  endtask

  task automatic run_frame(input frame_t f);
    int bad;
    int exp;
    int tot;
    start_frame(f.a);
    pq.delete();
    case (f.mode)
      0: begin
        repeat (f.na) pq.push_back(f.a);
        repeat (f.nb) pq.push_back(f.b);
      end
      1: begin
        for (int k = 0; k < f.na; k++) begin
          pq.push_back(f.a);
          pq.push_back(f.b);
        end
      end
      2: begin
        for (int k = 0; k < f.na; k++) begin
          pq.push_back(f.a);
          pq.push_back(-1);
        end
        for (int k = 0; k < f.nb; k++) begin
          pq.push_back(f.b);
          pq.push_back(-1);
        end
        void'(pq.pop_back());
      end
      default: ;
    endcase
    send_pixels();
    check({f.name, "_total_at_flush"}, int'(bus.total), f.exp_total);
    drain(f.rdy_mode, -1, 3000);
    check({f.name, "_pairs"}, n_got, NB);
    check({f.name, "_valid_done"}, int'(bus.out_valid), 0);
    check({f.name, "_done"}, int'(bus.done), 1);
    check({f.name, "_busy_done"}, int'(bus.busy), 0);
    check({f.name, "_n_a"}, got_n[f.a], f.exp_a);
    check({f.name, "_n_b"}, got_n[f.b], f.exp_b);
    bad = 0;
    for (int k = 0; k < NB; k++) begin
      exp = 0;
      if (k != f.a && k != f.b && got_n[k] != exp) bad++;
    end
    check({f.name, "_other_bins_nonzero"}, bad, 0);
    // Stray pixels in DONE must not disturb the result.
    tot = int'(bus.total);
    for (int k = 0; k < 4; k++) begin
      bus.pix_valid = 1'b1;
      bus.pix_data  = PW'(f.a);
      bus.frame_end = 1'b1;
      tick();
    end
    bus.pix_valid = 1'b0;
    bus.frame_end = 1'b0;
    check({f.name, "_total_in_done"}, tot, f.exp_total);
    check({f.name, "_total_after_pulses"}, int'(bus.total), f.exp_total);
    check({f.name, "_done_held"}, int'(bus.done), 1);
  endtask

  initial begin
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.pix_valid = 1'b0;
    bus.pix_data  = '0;
    bus.frame_end = 1'b0;
    bus.out_ready = 1'b0;

    vecs[0] = '{"basic", 5,   200, 3,    1,  0, 0, 3,    1,  4};
    vecs[1] = '{"run7",  7,   9,   1000, 0,  0, 0, 1000, 0,  1000};
    vecs[2] = '{"alt",   3,   4,   50,   50, 1, 1, 50,   50, 100};
    vecs[3] = '{"gaps",  255, 0,   2,    3,  2, 1, 2,    3,  5};
    vecs[4] = '{"sat",   9,   10,  1100, 2,  0, 0, 1023, 2,  1023};
    vecs[5] = '{"empty", 11,  12,  0,    0,  3, 1, 0,    0,  0};
    vecs[6] = '{"clean", 60,  61,  4,    6,  2, 1, 4,    6,  10};

    repeat (3) tick();
    check("rst_valid", int'(bus.out_valid), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_total", int'(bus.total), 0);
    reset = 1'b0;
    tick();
    check("idle_busy", int'(bus.busy), 0);

    for (int v = 0; v < 6; v++) run_frame(vecs[v]);

    // Stray start during ACCUM, then reset while bin 100 is presented.
    start_frame(77);
    for (int k = 0; k < 3; k++) begin
      bus.pix_valid = 1'b1;
      bus.pix_data  = 8'd50;
      tick();
    end
    bus.pix_valid = 1'b0;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    check("stray_start_busy", int'(bus.busy), 1);
    bus.pix_valid = 1'b1;
    bus.pix_data  = 8'd50;
    bus.frame_end = 1'b1;
    tick();
    bus.pix_valid = 1'b0;
    bus.frame_end = 1'b0;
    check("stray_start_total", int'(bus.total), 4);
    drain(0, 100, 400);
    check("stop_valid", int'(bus.out_valid), 1);
    check("stop_index", int'(bus.out_i), 100);
    check("stop_n50", got_n[50], 4);
    reset = 1'b1;
    tick();
    check("midrst_valid", int'(bus.out_valid), 0);
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_done", int'(bus.done), 0);
    check("midrst_total", int'(bus.total), 0);
    reset         = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) tick();
    bus.out_ready = 1'b0;
    check("postrst_valid", int'(bus.out_valid), 0);
    check("postrst_busy", int'(bus.busy), 0);

    run_frame(vecs[6]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
